// File: rtl/snake_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// snake_pkg : shared game codes, arena bounds and cell geometry
// Rev 1.0
// ------------------------------------------------------------------
package snake_pkg;

    localparam logic [1:0] START = 2'b00;
    localparam logic [1:0] PLAY  = 2'b10;
    localparam logic [1:0] DIE   = 2'b11;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        WALL = 2'd3
    } cube_t;

    localparam logic [5:0] ARENA_X_MIN = 6'd1;
    localparam logic [5:0] ARENA_X_MAX = 6'd38;
    localparam logic [5:0] ARENA_Y_MIN = 6'd1;
    localparam logic [5:0] ARENA_Y_MAX = 6'd28;
    localparam int         CELL_SHIFT  = 4;

    localparam logic [5:0]  APPLE_X_RST = 6'd20;
    localparam logic [5:0]  APPLE_Y_RST = 6'd15;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        PLACE = 2'd0,
        ARMED = 2'd1,
        EATEN = 2'd2
    } apple_state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ------------------------------------------------------------------
// lfsr16 : free-running 16-bit Fibonacci LFSR, loads seed on reset
// Rev 1.0
// ------------------------------------------------------------------
module lfsr16
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= seed;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/apple_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// apple_gen : places apples on random free cells and issues grow pulses
// Rev 1.0
// ------------------------------------------------------------------
module apple_gen
    import snake_pkg::*;
#(
    parameter logic [5:0] X_MIN    = ARENA_X_MIN,
    parameter logic [5:0] X_MAX    = ARENA_X_MAX,
    parameter logic [5:0] Y_MIN    = ARENA_Y_MIN,
    parameter logic [5:0] Y_MAX    = ARENA_Y_MAX,
    parameter int         ADD_HOLD = 8
) (
    input  logic       CLK_50M,
    input  logic       RSTn,
    input  logic [1:0] game_status,
    input  logic [5:0] head_x,
    input  logic [5:0] head_y,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic       add_cube,
    output logic [5:0] apple_x,
    output logic [5:0] apple_y,
    output logic       apple_pixel,
    output logic [7:0] eat_count
);

    localparam int              HOLD_W    = (ADD_HOLD > 1) ? $clog2(ADD_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ADD_HOLD - 1);

    apple_state_t      state, state_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic              add_nx;
    logic [5:0]        apple_x_nx, apple_y_nx;
    logic [7:0]        eat_nx;

    logic [15:0] lfsr;
    logic [5:0]  cx, cy;
    logic [5:0]  px_cell, py_cell;
    logic        cand_ok, head_hit;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (CLK_50M),
        .rst_n (RSTn),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    assign cx          = lfsr[5:0];
    assign cy          = lfsr[13:8];
    assign lfsr_unused = ^{lfsr[15:14], lfsr[7:6]};

    // Rejecting the head cell keeps a parked head from re-eating at once
    assign cand_ok  = (cx >= X_MIN) && (cx <= X_MAX) &&
                      (cy >= Y_MIN) && (cy <= Y_MAX) &&
                      !((cx == head_x) && (cy == head_y));
    assign head_hit = (head_x == apple_x) && (head_y == apple_y);

    always_comb begin
        state_nx   = state;
        hold_nx    = hold;
        add_nx     = add_cube;
        apple_x_nx = apple_x;
        apple_y_nx = apple_y;
        eat_nx     = eat_count;
        case (state)
            PLACE: begin
                if (cand_ok) begin
                    apple_x_nx = cx;
                    apple_y_nx = cy;
                    state_nx   = ARMED;
                end
            end
            ARMED: begin
                if ((game_status == PLAY) && head_hit) begin
                    add_nx   = 1'b1;
                    hold_nx  = HOLD_LOAD;
                    state_nx = EATEN;
                    if (eat_count != 8'hFF) begin
                        eat_nx = eat_count + 8'd1;
                    end
                end
            end
            EATEN: begin
                if (hold == '0) begin
                    add_nx   = 1'b0;
                    state_nx = PLACE;
                end else begin
                    hold_nx = hold - 1'b1;
                end
            end
            default: begin
                add_nx   = 1'b0;
                state_nx = PLACE;
            end
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ARMED;
            hold      <= '0;
            add_cube  <= 1'b0;
            apple_x   <= APPLE_X_RST;
            apple_y   <= APPLE_Y_RST;
            eat_count <= 8'd0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            add_cube  <= add_nx;
            apple_x   <= apple_x_nx;
            apple_y   <= apple_y_nx;
            eat_count <= eat_nx;
        end
    end

    assign px_cell = 6'(x_pos >> CELL_SHIFT);
    assign py_cell = 6'(y_pos >> CELL_SHIFT);

    assign apple_pixel = (state == ARMED) &&
                         (x_pos < 10'd640) && (y_pos < 10'd480) &&
                         (px_cell == apple_x) && (py_cell == apple_y);

endmodule
`default_nettype wire

// File: tb/tb_apple_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_apple_gen : scoreboard bench for apple_gen
// Rev 1.0
// ------------------------------------------------------------------
module tb_apple_gen;

    localparam int         ADD_HOLD = 8;
    localparam logic [1:0] PLAY     = 2'b10;

    logic       CLK_50M = 1'b0;
    logic       RSTn    = 1'b0;
    logic [1:0] game_status;
    logic [5:0] head_x, head_y;
    logic [9:0] x_pos, y_pos;
    logic       add_cube, apple_pixel;
    logic [5:0] apple_x, apple_y;
    logic [7:0] eat_count;

    typedef struct {
        logic [7:0] eat;
        logic [5:0] ax;
        logic [5:0] ay;
        int         place;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] lfsr_m;
    logic [5:0]  exp_ax, exp_ay;
    logic [7:0]  exp_eat;

    apple_gen #(
        .X_MIN    (6'd1),
        .X_MAX    (6'd38),
        .Y_MIN    (6'd1),
        .Y_MAX    (6'd28),
        .ADD_HOLD (ADD_HOLD)
    ) dut (
        .CLK_50M     (CLK_50M),
        .RSTn        (RSTn),
        .game_status (game_status),
        .head_x      (head_x),
        .head_y      (head_y),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .add_cube    (add_cube),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_pixel (apple_pixel),
        .eat_count   (eat_count)
    );

    always #10 CLK_50M = ~CLK_50M;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic cell_ok(input logic [5:0] cx, input logic [5:0] cy,
                                     input logic [5:0] hx, input logic [5:0] hy);
        return (cx >= 6'd1) && (cx <= 6'd38) && (cy >= 6'd1) && (cy <= 6'd28) &&
               !((cx == hx) && (cy == hy));
    endfunction

    // v0 is the LFSR value held during the first hold cycle; the first
    // placement decision happens ADD_HOLD+1 edges after the eat edge.
    function automatic void predict(input logic [15:0] v0, input logic [5:0] hx,
                                    input logic [5:0] hy, output logic [5:0] ax,
                                    output logic [5:0] ay, output int n);
        logic [15:0] v;
        v = v0;
        for (int k = 0; k < ADD_HOLD; k++) v = lfsr_step(v);
        n = ADD_HOLD + 1;
        while (!cell_ok(v[5:0], v[13:8], hx, hy) && n < 70000) begin
            v = lfsr_step(v);
            n++;
        end
        ax = v[5:0];
        ay = v[13:8];
    endfunction

    always @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) lfsr_m <= 16'hACE1;
        else       lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_eat(input bit pix_chk);
        logic [5:0] ox, oy, nx, ny;
        int         n, hi, pc;
        exp_t       e;
        ox = exp_ax;
        oy = exp_ay;
        head_x = ox;
        head_y = oy;
        game_status = PLAY;
        if (pix_chk) begin
            x_pos = {ox, 4'h5};
            y_pos = {oy, 4'h3};
        end
        @(negedge CLK_50M);
        predict(lfsr_m, ox, oy, nx, ny, n);
        exp_eat = (exp_eat == 8'hFF) ? 8'hFF : exp_eat + 8'd1;
        sb.push_back('{eat: exp_eat, ax: nx, ay: ny, place: n - ADD_HOLD});
        hi = 0;
        while (add_cube && hi < 64) begin
            if (pix_chk) check("pixel_eaten", apple_pixel, 0);
            hi++;
            @(negedge CLK_50M);
        end
        check("hold_len", hi, ADD_HOLD);
        pc = 0;
        while (apple_x == ox && apple_y == oy && pc < 70000) begin
            if (pix_chk) check("pixel_place", apple_pixel, 0);
            pc++;
            @(negedge CLK_50M);
        end
        e = sb.pop_front();
        check("place_len", pc, e.place);
        check("apple_x", apple_x, e.ax);
        check("apple_y", apple_y, e.ay);
        check("eat_count", eat_count, e.eat);
        check("apple_in_arena", (apple_x >= 6'd1) && (apple_x <= 6'd38) &&
                                (apple_y >= 6'd1) && (apple_y <= 6'd28), 1);
        if (pix_chk) begin
            x_pos = {apple_x, 4'h0};
            y_pos = {apple_y, 4'hF};
            #1;
            check("pixel_new_apple", apple_pixel, 1);
        end
        exp_ax = e.ax;
        exp_ay = e.ay;
    endtask

    int pix_x [6] = '{320, 335, 336, 319, 320, 320};
    int pix_y [6] = '{240, 255, 240, 240, 256, 239};
    int pix_e [6] = '{1,   1,   0,   0,   0,   0};

    initial begin
        int seen;
        game_status = 2'b00;
        head_x = 6'd0;
        head_y = 6'd0;
        x_pos  = 10'd0;
        y_pos  = 10'd0;
        exp_ax = 6'd20;
        exp_ay = 6'd15;
        exp_eat = 8'd0;

        repeat (3) @(negedge CLK_50M);
        check("rst_apple_x", apple_x, 20);
        check("rst_apple_y", apple_y, 15);
        check("rst_add_cube", add_cube, 0);
        check("rst_eat_count", eat_count, 0);
        RSTn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            x_pos = 10'(pix_x[i]);
            y_pos = 10'(pix_y[i]);
            #1;
            check("pixel_window", apple_pixel, pix_e[i]);
        end

        // Head on the apple but not playing: must never eat
        head_x = 6'd20;
        head_y = 6'd15;
        seen = 0;
        repeat (100) begin
            @(negedge CLK_50M);
            seen = seen | int'(add_cube);
        end
        check("noplay_add_cube", seen, 0);
        check("noplay_eat_count", eat_count, 0);

        do_eat(1'b1);

        seen = 0;
        repeat (10000) begin
            @(negedge CLK_50M);
            seen = seen + int'(add_cube);
        end
        check("park_extra_pulses", seen, 0);
        check("park_apple_on_head", (apple_x == head_x) && (apple_y == head_y), 0);

        for (int i = 1; i < 1000; i++) do_eat(1'b0);
        check("eat_saturated", eat_count, 255);

        // Reset three cycles into EATEN
        head_x = exp_ax;
        head_y = exp_ay;
        game_status = PLAY;
        repeat (3) @(negedge CLK_50M);
        check("pre_rst_add_cube", add_cube, 1);
        #3 RSTn = 1'b0;
        #1;
        check("midrst_add_cube", add_cube, 0);
        check("midrst_apple_x", apple_x, 20);
        check("midrst_apple_y", apple_y, 15);
        check("midrst_eat_count", eat_count, 0);
        game_status = 2'b00;
        repeat (2) @(negedge CLK_50M);
        RSTn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge CLK_50M);
            seen = seen | int'(add_cube);
        end
        check("post_rst_add_cube", seen, 0);
        check("post_rst_apple_x", apple_x, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
